// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream read path.
package bitstream_pkg;

  localparam int DEF_MAX_BITS  = 32;
  localparam int FIFO_CAP_BITS = 65536;

  // Width of a field-length value able to hold 0..max_bits.
  function automatic int len_w(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bit_collector.sv
// Shift accumulator: packs incoming bits MSB-first, right-justified, and
// counts how many have arrived since the last clear.
module bit_collector
  import bitstream_pkg::*;
#(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int LEN_W    = len_w(MAX_BITS)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                i_clear,
  input  logic                i_bit,
  input  logic                i_bit_valid,
  output logic [MAX_BITS-1:0] o_value,
  output logic [LEN_W-1:0]    o_count
);

  logic [MAX_BITS-1:0] r_value;
  logic [LEN_W-1:0]    r_count;

  // Shift each valid bit in at the LSB; earlier bits move toward the MSB.
  always_ff @(posedge clk) begin
    if (srst || i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_bit_valid) begin
      r_value <= (r_value << 1) | MAX_BITS'(i_bit);
      r_count <= r_count + LEN_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_count = r_count;

endmodule

// File: rtl/bit_reader_ctrl.sv
// Bitstream FIFO sequencer: gates upstream byte writes and serves
// variable-length field reads one bit per cycle to a single consumer.
module bit_reader_ctrl
  import bitstream_pkg::*;
#(
  parameter int          MAX_BITS   = DEF_MAX_BITS,
  parameter logic [15:0] FILL_LIMIT = 16'd65520,
  localparam int         LEN_W      = len_w(MAX_BITS)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [MAX_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         bits_consumed,
  output logic [7:0]          fifo_din,
  output logic                fifo_wr_en,
  output logic                fifo_rd_en,
  input  logic                fifo_dout,
  input  logic                fifo_d_valid,
  input  logic [15:0]         fifo_dcount
);

  rd_state_e           r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [31:0]         r_bits_consumed;

  logic [LEN_W-1:0]    w_len_clamp;
  logic                w_accept;
  logic                w_bit_valid;
  logic                w_last;
  logic [MAX_BITS-1:0] w_value;
  logic [LEN_W-1:0]    w_count;

  // Write side is purely combinational and independent of the read FSM;
  // the fill limit leaves room for one more byte below FIFO capacity.
  always_comb begin
    in_ready   = !srst && (fifo_dcount <= FILL_LIMIT);
    fifo_wr_en = in_valid && in_ready;
    fifo_din   = in_data;
  end

  // Read-side handshakes and the per-bit FIFO pop.
  always_comb begin
    w_len_clamp = (req_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : req_len;
    req_ready   = !srst && (r_state == ST_IDLE);
    w_accept    = req_ready && req_valid;
    // Never pop an empty FIFO; a mid-field underrun simply stalls here.
    fifo_rd_en  = !srst && (r_state == ST_READ) && (r_issued < r_len) &&
                  (fifo_dcount != 16'd0);
    w_bit_valid = (r_state == ST_READ) && fifo_d_valid;
    w_last      = w_bit_valid && ((w_count + LEN_W'(1)) == r_len);
    out_valid   = (r_state == ST_DONE);
    out_data    = w_value;
  end

  bit_collector #(
    .MAX_BITS (MAX_BITS),
    .LEN_W    (LEN_W)
  ) u_collector (
    .clk         (clk),
    .srst        (srst),
    .i_clear     (w_accept),
    .i_bit       (fifo_dout),
    .i_bit_valid (w_bit_valid),
    .o_value     (w_value),
    .o_count     (w_count)
  );

  // Field FSM: accept a request, issue/collect len bits, hold the result
  // until the consumer takes it, then account the delivered bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_issued        <= '0;
      r_bits_consumed <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_len    <= w_len_clamp;
            r_issued <= '0;
            r_state  <= (w_len_clamp == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (fifo_rd_en) r_issued <= r_issued + LEN_W'(1);
          if (w_last)     r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_bits_consumed <= r_bits_consumed + 32'(r_len);
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bits_consumed = r_bits_consumed;

endmodule
